// File: rtl/toycore_pkg.sv
// toycore_pkg: condition codes, NZCV bit positions and ALU op encodings
// shared across the toycore execute and retire stages.
package toycore_pkg;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_HI = 4'd9;
    localparam logic [3:0] COND_LS = 4'd10;
    localparam logic [3:0] COND_GE = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GT = 4'd13;
    localparam logic [3:0] COND_LE = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADC  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SBB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_MOV  = 4'd7,
        ALU_CMP  = 4'd8,
        ALU_TEST = 4'd9,
        ALU_SHL  = 4'd10,
        ALU_SHR  = 4'd11
    } alu_op_t;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: evaluates a 4-bit condition code against NZCV flags.
module cond_eval
    import toycore_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       cond_true
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = w_z;
            COND_NE: cond_true = ~w_z;
            COND_CS: cond_true = w_c;
            COND_CC: cond_true = ~w_c;
            COND_MI: cond_true = w_n;
            COND_PL: cond_true = ~w_n;
            COND_VS: cond_true = w_v;
            COND_VC: cond_true = ~w_v;
            COND_HI: cond_true = w_c & ~w_z;
            COND_LS: cond_true = ~w_c | w_z;
            COND_GE: cond_true = (w_n == w_v);
            COND_LT: cond_true = (w_n != w_v);
            COND_GT: cond_true = ~w_z & (w_n == w_v);
            COND_LE: cond_true = w_z | (w_n != w_v);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: aligns issue sideband with the registered ALU result, commits
// it to the register file and NZCV flags, and forwards live flags to the ALU.
module alu_writeback
    import toycore_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_we,
    input  logic              issue_fe,
    input  logic              flush,
    input  logic [31:0]       alu_q,
    input  logic              alu_qc,
    input  logic              alu_qv,
    output logic              flag_c,
    output logic [3:0]        flags,
    input  logic [3:0]        cond,
    output logic              cond_true,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_rd,
    output logic [31:0]       wb_data
);

    logic              r_a_valid;
    logic [REG_AW-1:0] r_a_rd;
    logic              r_a_we;
    logic              r_a_fe;
    logic [3:0]        r_flags;
    logic              r_wb_en;
    logic [REG_AW-1:0] r_wb_rd;
    logic [31:0]       r_wb_data;

    logic       w_commit;
    logic       w_flag_upd;
    logic [3:0] w_live;

    assign w_commit   = r_a_valid & ~flush;
    assign w_flag_upd = w_commit & r_a_fe;
    assign w_live     = {alu_q[31], alu_q == 32'd0, alu_qc, alu_qv};

    // Bypass the flags register so a dependent op issued right behind a
    // flag-setting op sees its carry without a stall.
    assign flags  = w_flag_upd ? w_live : r_flags;
    assign flag_c = flags[FLAG_C];

    assign wb_en   = r_wb_en;
    assign wb_rd   = r_wb_rd;
    assign wb_data = r_wb_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_rd    <= '0;
            r_a_we    <= 1'b0;
            r_a_fe    <= 1'b0;
            r_flags   <= 4'b0000;
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= 32'd0;
        end else begin
            r_a_valid <= issue_valid & ~flush;
            r_a_rd    <= issue_rd;
            r_a_we    <= issue_we;
            r_a_fe    <= issue_fe;
            r_wb_en   <= w_commit & r_a_we;
            if (w_commit & r_a_we) begin
                r_wb_rd   <= r_a_rd;
                r_wb_data <= alu_q;
            end
            if (w_flag_upd)
                r_flags <= w_live;
        end
    end

    cond_eval u_cond_eval (
        .flags     (flags),
        .cond      (cond),
        .cond_true (cond_true)
    );

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed vectors with hand-computed expectations for the
// retire stage: commit, carry forwarding, compare, flush, reset and conditions.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [3:0]  issue_rd;
    logic        issue_we;
    logic        issue_fe;
    logic        flush;
    logic [31:0] alu_q;
    logic        alu_qc;
    logic        alu_qv;
    logic        flag_c;
    logic [3:0]  flags;
    logic [3:0]  cond;
    logic        cond_true;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_writeback #(.REG_AW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_we    (issue_we),
        .issue_fe    (issue_fe),
        .flush       (flush),
        .alu_q       (alu_q),
        .alu_qc      (alu_qc),
        .alu_qv      (alu_qv),
        .flag_c      (flag_c),
        .flags       (flags),
        .cond        (cond),
        .cond_true   (cond_true),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] rd, input logic we, input logic fe);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_we    = we;
        issue_fe    = fe;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_fe    = 1'b0;
    endtask

    task automatic alu(input logic [31:0] q, input logic qc, input logic qv);
        alu_q  = q;
        alu_qc = qc;
        alu_qv = qv;
    endtask

    task automatic set_flags(input logic [31:0] q, input logic qc, input logic qv);
        issue(4'd0, 1'b0, 1'b1);
        tick();
        idle();
        alu(q, qc, qv);
        tick();
        alu(32'h1234_5678, 1'b0, 1'b0);
    endtask

    task automatic sweep(input string tag, input logic [15:0] mask);
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #1;
            check($sformatf("%s_c%0d", tag, i), {31'd0, cond_true}, {31'd0, mask[i]});
        end
        cond = 4'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        issue_rd = 4'd0;
        flush    = 1'b0;
        alu(32'd0, 1'b0, 1'b0);
        cond = 4'd0;
        tick();
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_flag_c", {31'd0, flag_c}, 32'd0);
        check("rst_cond_al", {31'd0, cond_true}, 32'd1);
        cond = 4'd1;
        #1;
        check("rst_cond_eq", {31'd0, cond_true}, 32'd0);
        cond = 4'd0;
        tick();
        rst = 1'b0;
        tick();

        // add rd=3 producing zero with carry out
        issue(4'd3, 1'b1, 1'b1);
        tick();
        idle();
        alu(32'd0, 1'b1, 1'b0);
        #1;
        check("add_flag_c", {31'd0, flag_c}, 32'd1);
        check("add_fwd_flags", {28'd0, flags}, 32'h6);
        check("add_no_early_wb", {31'd0, wb_en}, 32'd0);
        tick();
        alu(32'hDEAD_BEEF, 1'b0, 1'b1);
        #1;
        check("add_wb_en", {31'd0, wb_en}, 32'd1);
        check("add_wb_rd", {28'd0, wb_rd}, 32'd3);
        check("add_wb_data", wb_data, 32'd0);
        check("add_flags_reg", {28'd0, flags}, 32'h6);
        tick();
        check("add_wb_pulse", {31'd0, wb_en}, 32'd0);

        // adc chain at full rate
        issue(4'd1, 1'b1, 1'b1);
        tick();
        issue(4'd2, 1'b1, 1'b1);
        alu(32'hFFFF_FFFF, 1'b1, 1'b0);
        #1;
        check("chain_flag_c", {31'd0, flag_c}, 32'd1);
        check("chain_flags", {28'd0, flags}, 32'hA);
        tick();
        idle();
        alu(32'd1, 1'b0, 1'b0);
        #1;
        check("chain_wb_en0", {31'd0, wb_en}, 32'd1);
        check("chain_wb_rd0", {28'd0, wb_rd}, 32'd1);
        check("chain_wb_data0", wb_data, 32'hFFFF_FFFF);
        check("chain_flag_c2", {31'd0, flag_c}, 32'd0);
        tick();
        check("chain_wb_en1", {31'd0, wb_en}, 32'd1);
        check("chain_wb_rd1", {28'd0, wb_rd}, 32'd2);
        check("chain_wb_data1", wb_data, 32'd1);
        check("chain_flags_reg", {28'd0, flags}, 32'h0);
        tick();
        check("chain_wb_end", {31'd0, wb_en}, 32'd0);

        // cmp: flags only, no write
        issue(4'd7, 1'b0, 1'b1);
        tick();
        idle();
        alu(32'h8000_0000, 1'b0, 1'b1);
        cond = 4'd11;
        #1;
        check("cmp_fwd_flags", {28'd0, flags}, 32'h9);
        check("cmp_ge", {31'd0, cond_true}, 32'd1);
        cond = 4'd12;
        #1;
        check("cmp_lt", {31'd0, cond_true}, 32'd0);
        cond = 4'd0;
        tick();
        alu(32'd0, 1'b1, 1'b0);
        #1;
        check("cmp_no_wb", {31'd0, wb_en}, 32'd0);
        check("cmp_wb_rd_hold", {28'd0, wb_rd}, 32'd2);
        check("cmp_wb_data_hold", wb_data, 32'd1);
        check("cmp_flags_reg", {28'd0, flags}, 32'h9);

        // flush while stage A holds add rd=5, with a same-cycle issue of rd=6
        issue(4'd5, 1'b1, 1'b1);
        tick();
        issue(4'd6, 1'b1, 1'b1);
        flush = 1'b1;
        alu(32'd5, 1'b1, 1'b0);
        #1;
        check("flush_flags_reg", {28'd0, flags}, 32'h9);
        tick();
        idle();
        flush = 1'b0;
        alu(32'd0, 1'b1, 1'b0);
        #1;
        check("flush_no_wb", {31'd0, wb_en}, 32'd0);
        check("flush_dropped_fwd", {28'd0, flags}, 32'h9);
        tick();
        check("flush_no_wb2", {31'd0, wb_en}, 32'd0);
        check("flush_flags_hold", {28'd0, flags}, 32'h9);
        check("flush_rd_hold", {28'd0, wb_rd}, 32'd2);

        // reset while an op sits in stage A and a write is on the port
        issue(4'd9, 1'b1, 1'b1);
        tick();
        issue(4'd4, 1'b1, 1'b1);
        alu(32'h11, 1'b0, 1'b0);
        tick();
        idle();
        alu(32'd0, 1'b1, 1'b0);
        #1;
        check("mid_wb_en", {31'd0, wb_en}, 32'd1);
        check("mid_wb_rd", {28'd0, wb_rd}, 32'd9);
        check("mid_fwd_flags", {28'd0, flags}, 32'h6);
        rst = 1'b1;
        #1;
        check("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("mid_rst_wb_rd", {28'd0, wb_rd}, 32'd0);
        check("mid_rst_flags", {28'd0, flags}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("post_rst_flags", {28'd0, flags}, 32'h0);
        tick();
        check("post_rst_wb_en2", {31'd0, wb_en}, 32'd0);

        // condition sweep against committed flags
        set_flags(32'd1, 1'b0, 1'b0);
        check("sweep_f0000", {28'd0, flags}, 32'h0);
        sweep("f0000", 16'h2D55);
        set_flags(32'd0, 1'b0, 1'b0);
        check("sweep_f0100", {28'd0, flags}, 32'h4);
        sweep("f0100", 16'h4D53);
        set_flags(32'd1, 1'b1, 1'b0);
        check("sweep_f0010", {28'd0, flags}, 32'h2);
        sweep("f0010", 16'h2B4D);
        set_flags(32'h8000_0000, 1'b0, 1'b1);
        check("sweep_f1001", {28'd0, flags}, 32'h9);
        sweep("f1001", 16'h2CB5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
